mavg_filter_param: RTL and testbench

Parametrised moving-average filter, the successor to the fixed 4-tap, 8-bit sensor averager. Accepts a qualified sample stream and keeps a DEPTH-deep circular window with a running sum. Each accepted sample produces a registered average, truncated or rounded. Adds a warm-up gate, synchronous window clear, and a tap read-back port for the window contents; sits between the sensor front-end and downstream control logic.

---
 rtl/mavg_pkg.sv | 20 ++
 rtl/mavg_ring_buf.sv | 50 +++++
 rtl/mavg_filter_param.sv | 113 +++++++++++
 tb/tb_mavg_filter_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared helpers for the parametrised moving-average filter.
//   sum_w       : width of the running sum (sample width plus log2 of depth)
//   depth_ok    : legal window-depth range, checked at elaboration
//   round_const : bias added before the divide-by-depth shift
package mavg_pkg;

  function automatic int sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic bit depth_ok(input int log2_depth);
    return (log2_depth >= 1) && (log2_depth <= 6);
  endfunction

  // Half an LSB of the shifted result gives round-half-up; zero gives truncation.
  function automatic int round_const(input int log2_depth, input int round);
    return (round != 0) ? (1 << (log2_depth - 1)) : 0;
  endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// Circular sample window for the moving-average filter.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   clear          : synchronous flush of all entries and the write pointer
//   wr_en, wr_data : write the newest sample over the oldest slot
//   tap_sel        : read-back index, 0 = newest sample
//   oldest         : entry about to be overwritten (0 until the window first fills)
//   tap_data       : combinational read of the selected entry
module mavg_ring_buf
  import mavg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [LOG2_DEPTH-1:0] tap_sel,
  output logic [DATA_W-1:0]     oldest,
  output logic [DATA_W-1:0]     tap_data
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0]     win_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] tap_idx;

  // Entries are zeroed on reset/clear so the oldest slot contributes nothing
  // to the running sum until the window has wrapped once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else if (wr_en) begin
      win_q[wr_ptr_q] <= wr_data;
      wr_ptr_q        <= wr_ptr_q + LOG2_DEPTH'(1);
    end
  end

  // Pointer arithmetic wraps naturally in LOG2_DEPTH bits.
  assign tap_idx  = wr_ptr_q - LOG2_DEPTH'(1) - tap_sel;
  assign oldest   = win_q[wr_ptr_q];
  assign tap_data = win_q[tap_idx];

endmodule

// File: rtl/mavg_filter_param.sv
// Parametrised moving-average filter with running sum.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   in_valid     : new_data accepted this cycle (unless clear is high)
//   new_data     : input sample (unsigned)
//   clear        : synchronous window flush; beats a same-cycle sample
//   warmup_gate  : 1 = hold off out_valid until the window is full
//   tap_sel      : window read-back index, 0 = newest
//   tap_data     : window sample at tap_sel
//   out_valid    : one-cycle pulse when sum/mov_avg were updated
//   mov_avg      : registered sum / DEPTH (truncated or rounded)
//   sum          : registered running sum of the window
//   fill_count   : samples in the window, saturating at DEPTH
//   full         : fill_count == DEPTH
// The divisor is always DEPTH, so the average ramps up through the
// zero-filled slots during warm-up.
module mavg_filter_param
  import mavg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            new_data,
  input  logic                         clear,
  input  logic                         warmup_gate,
  input  logic [LOG2_DEPTH-1:0]        tap_sel,
  output logic [DATA_W-1:0]            tap_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            mov_avg,
  output logic [DATA_W+LOG2_DEPTH-1:0] sum,
  output logic [LOG2_DEPTH:0]          fill_count,
  output logic                         full
);

  localparam int                  SUM_W   = sum_w(DATA_W, LOG2_DEPTH);
  localparam logic [SUM_W:0]      RND_C   = (SUM_W+1)'(round_const(LOG2_DEPTH, ROUND));
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(1 << LOG2_DEPTH);

  if (!depth_ok(LOG2_DEPTH)) begin : g_depth_chk
    $error("mavg_filter_param: LOG2_DEPTH must be in 1..6");
  end

  // Divide by DEPTH with optional half-LSB bias. The extra sum bit absorbs the
  // bias; the result always fits DATA_W because sum <= DEPTH*(2**DATA_W-1).
  function automatic logic [DATA_W-1:0] scale_avg(input logic [SUM_W:0] s);
    logic [SUM_W:0] t;
    t = (s + RND_C) >> LOG2_DEPTH;
    return DATA_W'(t);
  endfunction

  logic                  accept_p0;
  logic [DATA_W-1:0]     oldest_p0;
  logic [SUM_W:0]        sum_n_p0;
  logic [LOG2_DEPTH:0]   fill_n_p0;
  logic                  vld_n_p0;

  logic [SUM_W-1:0]      sum_p1;
  logic [DATA_W-1:0]     avg_p1;
  logic [LOG2_DEPTH:0]   fill_p1;
  logic                  vld_p1;

  assign accept_p0 = in_valid && !clear;

  mavg_ring_buf #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (accept_p0),
    .wr_data  (new_data),
    .tap_sel  (tap_sel),
    .oldest   (oldest_p0),
    .tap_data (tap_data)
  );

  // Stage p0: next sum, fill level and valid, combinational from the inputs.
  // The sum always contains the oldest entry, so the subtraction cannot underflow.
  always_comb begin
    sum_n_p0  = {1'b0, sum_p1} + (SUM_W+1)'(new_data) - (SUM_W+1)'(oldest_p0);
    fill_n_p0 = (fill_p1 == DEPTH_C) ? fill_p1 : fill_p1 + (LOG2_DEPTH+1)'(1);
    vld_n_p0  = !warmup_gate || (fill_n_p0 == DEPTH_C);
  end

  // Stage p1: registered outputs, updated on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum_p1  <= '0;
      avg_p1  <= '0;
      fill_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (accept_p0) begin
      sum_p1  <= sum_n_p0[SUM_W-1:0];
      avg_p1  <= scale_avg(sum_n_p0);
      fill_p1 <= fill_n_p0;
      vld_p1  <= vld_n_p0;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign sum        = sum_p1;
  assign mov_avg    = avg_p1;
  assign fill_count = fill_p1;
  assign full       = (fill_p1 == DEPTH_C);
  assign out_valid  = vld_p1;

endmodule

// File: tb/tb_mavg_filter_param.sv
// Directed bench for mavg_filter_param: one truncating and one rounding
// instance share the same stimulus.
module tb_mavg_filter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic       warmup_gate = 1'b0;
  logic [7:0] new_data = '0;
  logic [1:0] tap_sel = '0;

  logic [7:0] tap_t, tap_r, avg_t, avg_r;
  logic [9:0] sum_t, sum_r;
  logic [2:0] fill_t, fill_r;
  logic       ov_t, ov_r, full_t, full_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mavg_filter_param #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(0)) u_dut_t (
    .clk(clk), .reset(reset), .in_valid(in_valid), .new_data(new_data),
    .clear(clear), .warmup_gate(warmup_gate), .tap_sel(tap_sel),
    .tap_data(tap_t), .out_valid(ov_t), .mov_avg(avg_t), .sum(sum_t),
    .fill_count(fill_t), .full(full_t)
  );

  mavg_filter_param #(.DATA_W(8), .LOG2_DEPTH(2), .ROUND(1)) u_dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .new_data(new_data),
    .clear(clear), .warmup_gate(warmup_gate), .tap_sel(tap_sel),
    .tap_data(tap_r), .out_valid(ov_r), .mov_avg(avg_r), .sum(sum_r),
    .fill_count(fill_r), .full(full_r)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one sample for exactly one edge, then sample outputs #1 later.
  task automatic send(input int d, input bit clr);
    @(negedge clk);
    new_data = 8'(d);
    in_valid = 1'b1;
    clear    = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic check_taps(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    int exp_tap[4];
    exp_tap = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      tap_sel = 2'(i);
      #1;
      check($sformatf("%s_tap%0d", tag, i), int'(tap_t), exp_tap[i]);
    end
    tap_sel = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s5[5], a5t[5], a5r[5], f5[5];
    int wsum[9];
    int bsum[6], bavg_r[6], bavg_t[6];
    int wov[5];

    // Reset state
    do_reset();
    check("rst_sum_t", int'(sum_t), 0);
    check("rst_avg_t", int'(avg_t), 0);
    check("rst_fill_t", int'(fill_t), 0);
    check("rst_full_t", int'(full_t), 0);
    check("rst_ov_t", int'(ov_t), 0);
    check("rst_tap_t", int'(tap_t), 0);
    check("rst_sum_r", int'(sum_r), 0);
    check("rst_avg_r", int'(avg_r), 0);
    check("rst_fill_r", int'(fill_r), 0);
    check("rst_full_r", int'(full_r), 0);
    check("rst_ov_r", int'(ov_r), 0);
    check("rst_tap_r", int'(tap_r), 0);

    // Basic stream 12,7,10,5,20, back-to-back
    s5  = '{12, 19, 29, 34, 42};
    a5t = '{3, 4, 7, 8, 10};
    a5r = '{3, 5, 7, 9, 11};
    f5  = '{1, 2, 3, 4, 4};
    begin
      int smp[5];
      smp = '{12, 7, 10, 5, 20};
      for (int i = 0; i < 5; i++) begin
        send(smp[i], 1'b0);
        check($sformatf("basic_sum%0d", i), int'(sum_t), s5[i]);
        check($sformatf("basic_avg%0d", i), int'(avg_t), a5t[i]);
        check($sformatf("basic_ov%0d", i), int'(ov_t), 1);
        check($sformatf("basic_fill%0d", i), int'(fill_t), f5[i]);
        check($sformatf("basic_full%0d", i), int'(full_t), (i >= 3) ? 1 : 0);
        check($sformatf("round_avg%0d", i), int'(avg_r), a5r[i]);
      end
    end
    // Window is 20 (newest), 5, 10, 7
    check_taps("basic", 20, 5, 10, 7);

    // Idle cycle: outputs hold, no pulse
    @(posedge clk);
    #1;
    check("idle_ov", int'(ov_t), 0);
    check("idle_sum", int'(sum_t), 42);
    check("idle_avg", int'(avg_t), 10);

    // Reset mid-stream, then 4,4 and nine more samples to wrap the pointer
    do_reset();
    check("mid_rst_sum", int'(sum_t), 0);
    send(4, 1'b0);
    check("post_rst_sum0", int'(sum_t), 4);
    check("post_rst_fill0", int'(fill_t), 1);
    send(4, 1'b0);
    check("post_rst_sum1", int'(sum_t), 8);
    check_taps("post_rst", 4, 4, 0, 0);
    wsum = '{9, 11, 10, 10, 14, 18, 22, 26, 30};
    for (int i = 0; i < 9; i++) begin
      send(i + 1, 1'b0);
      check($sformatf("wrap_sum%0d", i), int'(sum_t), wsum[i]);
    end
    check("wrap_fill", int'(fill_t), 4);
    check("wrap_full", int'(full_t), 1);
    check("wrap_avg", int'(avg_t), 7);
    check_taps("wrap", 9, 8, 7, 6);

    // Clear beats a same-cycle sample
    do_reset();
    send(12, 1'b0);
    send(7, 1'b0);
    send(10, 1'b0);
    check("pre_clr_sum", int'(sum_t), 29);
    send(99, 1'b1);
    check("clr_sum", int'(sum_t), 0);
    check("clr_fill", int'(fill_t), 0);
    check("clr_avg", int'(avg_t), 0);
    check("clr_ov", int'(ov_t), 0);
    check("clr_tap0", int'(tap_t), 0);
    send(8, 1'b0);
    check("post_clr_sum", int'(sum_t), 8);
    check("post_clr_avg", int'(avg_t), 2);
    check("post_clr_avg_r", int'(avg_r), 2);
    check("post_clr_fill", int'(fill_t), 1);
    check_taps("post_clr", 8, 0, 0, 0);

    // Warm-up gate holds off out_valid until the window is full
    warmup_gate = 1'b1;
    do_reset();
    wov = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      send(i + 1, 1'b0);
      check($sformatf("warm_ov%0d", i), int'(ov_t), wov[i]);
    end
    check("warm_avg_last", int'(avg_t), 3);
    check("warm_sum_last", int'(sum_t), 14);
    warmup_gate = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) send(i + 1, 1'b0);
    check("warm_avg4_t", int'(avg_t), 2);

    // Full-scale samples: sum saturates naturally at 4*255
    do_reset();
    bsum   = '{255, 510, 765, 1020, 1020, 1020};
    bavg_r = '{64, 128, 191, 255, 255, 255};
    bavg_t = '{63, 127, 191, 255, 255, 255};
    for (int i = 0; i < 6; i++) begin
      send(255, 1'b0);
      check($sformatf("max_sum_r%0d", i), int'(sum_r), bsum[i]);
      check($sformatf("max_avg_r%0d", i), int'(avg_r), bavg_r[i]);
      check($sformatf("max_avg_t%0d", i), int'(avg_t), bavg_t[i]);
    end
    check("max_fill_r", int'(fill_r), 4);
    check("max_full_r", int'(full_r), 1);
    check("max_ov_r", int'(ov_r), 1);
    check("max_tap_r", int'(tap_r), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
